// File: rtl/aibcr3_dcc_interp_ctrl.sv
// Closed-loop DCC interpolator controller: settle, majority-vote the phase detector, step the thermometer code.
// Optional macro AIBCR3_DCC_CTRL_TRACK_EN keeps tracking (+/-1 per decision) after lock instead of freezing.
module aibcr3_dcc_interp_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CNT = 32,
  parameter int LOCK_REV   = 4,
  parameter int INIT_CODE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dcc_en,
  input  logic       dcc_start,
  input  logic       pd_in,
  input  logic       manual_en,
  input  logic [2:0] manual_code,
  output logic [6:0] sp,
  output logic [6:0] sn,
  output logic [2:0] dcc_code,
  output logic       dcc_busy,
  output logic       dcc_lock,
  output logic       dcc_sat
);

  localparam int SW = $clog2(SAMPLE_CNT);
  localparam int TW = $clog2(SETTLE_CYC + 1);
  localparam logic [2:0]  INIT = 3'(INIT_CODE);
  localparam logic [SW:0] HALF = (SW + 1)'(SAMPLE_CNT / 2);
`ifdef AIBCR3_DCC_CTRL_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_DECIDE, S_LOCKED
  } state_t;

  state_t        r_state;
  logic [2:0]    r_code;
  logic [6:0]    r_sp;
  logic [6:0]    r_sn;
  logic          r_busy;
  logic          r_lock;
  logic          r_sat;
  logic [TW-1:0] r_settle_cnt;
  logic [SW-1:0] r_sample_cnt;
  logic [SW:0]   r_ones_cnt;
  logic [3:0]    r_rev_cnt;
  logic          r_last_dir;
  logic          r_dir_valid;
  logic          r_pd_meta;
  logic          r_pd_sync;

  logic       w_dir_up;
  logic       w_at_limit;
  logic       w_rev;
  logic [2:0] w_code_step;

  function automatic logic [6:0] therm(input logic [2:0] c);
    logic [6:0] t;
    for (int i = 0; i < 7; i++) t[i] = (3'(i) < c);
    return t;
  endfunction

  // pd_in is asynchronous to the calibration clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pd_meta <= 1'b0;
      r_pd_sync <= 1'b0;
    end else begin
      r_pd_meta <= pd_in;
      r_pd_sync <= r_pd_meta;
    end
  end

  assign w_dir_up    = (r_ones_cnt > HALF);
  assign w_at_limit  = w_dir_up ? (r_code == 3'd7) : (r_code == 3'd0);
  assign w_code_step = w_dir_up ? (r_code + 3'd1) : (r_code - 3'd1);
  // saturated decisions never count as reversals and do not update the direction history
  assign w_rev       = !w_at_limit && r_dir_valid && (w_dir_up != r_last_dir);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_code       <= INIT;
      r_sp         <= therm(INIT);
      r_sn         <= ~therm(INIT);
      r_busy       <= 1'b0;
      r_lock       <= 1'b0;
      r_sat        <= 1'b0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_ones_cnt   <= '0;
      r_rev_cnt    <= '0;
      r_last_dir   <= 1'b0;
      r_dir_valid  <= 1'b0;
    end else if (manual_en) begin
      r_state <= S_IDLE;
      r_code  <= manual_code;
      r_sp    <= therm(manual_code);
      r_sn    <= ~therm(manual_code);
      r_busy  <= 1'b0;
      r_lock  <= 1'b0;
    end else if (!dcc_en) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_lock  <= 1'b0;
    end else if (dcc_start) begin
      r_state      <= S_SETTLE;
      r_code       <= INIT;
      r_sp         <= therm(INIT);
      r_sn         <= ~therm(INIT);
      r_busy       <= 1'b1;
      r_lock       <= 1'b0;
      r_sat        <= 1'b0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_ones_cnt   <= '0;
      r_rev_cnt    <= '0;
      r_last_dir   <= 1'b0;
      r_dir_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_SETTLE: begin
          if (r_settle_cnt == TW'(SETTLE_CYC - 1)) begin
            r_settle_cnt <= '0;
            r_ones_cnt   <= '0;
            r_state      <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_ones_cnt <= r_ones_cnt + {{SW{1'b0}}, r_pd_sync};
          if (r_sample_cnt == SW'(SAMPLE_CNT - 1)) begin
            r_sample_cnt <= '0;
            r_state      <= S_DECIDE;
          end else begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
          end
        end
        S_DECIDE: begin
          if (r_ones_cnt == HALF) begin
            r_lock  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= TRACK ? S_SETTLE : S_LOCKED;
          end else begin
            if (w_at_limit) begin
              r_sat <= 1'b1;
            end else begin
              r_code <= w_code_step;
              r_sp   <= therm(w_code_step);
              r_sn   <= ~therm(w_code_step);
            end
            if (r_lock) begin
              r_state <= S_SETTLE;
            end else begin
              r_rev_cnt <= r_rev_cnt + {3'b000, w_rev};
              if (!w_at_limit) begin
                r_last_dir  <= w_dir_up;
                r_dir_valid <= 1'b1;
              end
              if (w_rev && (r_rev_cnt == 4'(LOCK_REV - 1))) begin
                r_lock  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= TRACK ? S_SETTLE : S_LOCKED;
              end else begin
                r_state <= S_SETTLE;
              end
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign sp       = r_sp;
  assign sn       = r_sn;
  assign dcc_code = r_code;
  assign dcc_busy = r_busy;
  assign dcc_lock = r_lock;
  assign dcc_sat  = r_sat;

endmodule
